sdram_port_arbiter: RTL and testbench

- Shares the single host-side FIFO port of the SDRAM controller between two requesters, for example the RW test engine and a frame-buffer client.
- Runs in the test-clock domain, between the requesters and the controller's WR/WR_DATA/RD/RD_DATA pins.
- Grants whole bursts, alternating round-robin between the requesters, and routes write strobes and data down and read data back.
- Inserts a drain gap between bursts so read data is never attributed to the wrong requester.

---
 rtl/sdram_port_arbiter_if.sv | 54 +++++
 rtl/sdram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdram_port_arbiter_if
//
// Purpose:
//   Groups the requester-side and controller-side signals of the SDRAM host
//   port arbiter into a single bundle. Signal names keep the controller pin
//   naming (i* = into the arbiter, o* = out of the arbiter).
//
// Modports:
//   slave  - the arbiter itself (drives o*, samples i*)
//   master - the surrounding logic: requesters plus controller FIFO port
//
// Signals:
//   iREQ[1:0]      burst request per requester, level-sensitive
//   iDIR[1:0]      burst direction per requester (0 write, 1 read)
//   iSTB[1:0]      per-requester word strobe
//   iWDATA0/1      write data from requester 0 / 1
//   oGNT[1:0]      one-hot grant or 0
//   oRDATA         read data, broadcast to both requesters
//   oRVALID[1:0]   per-requester read-data valid
//   oWR, oWR_DATA  write strobe and data to the controller
//   oRD            read strobe to the controller
//   iRD_DATA       read data from the controller
//   oBUSY          arbiter not idle
//   oTIMEOUT[1:0]  sticky per-requester timeout flag
// ----------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [1:0]        iREQ;
    logic [1:0]        iDIR;
    logic [1:0]        iSTB;
    logic [DATA_W-1:0] iWDATA0;
    logic [DATA_W-1:0] iWDATA1;
    logic [1:0]        oGNT;
    logic [DATA_W-1:0] oRDATA;
    logic [1:0]        oRVALID;
    logic              oWR;
    logic [DATA_W-1:0] oWR_DATA;
    logic              oRD;
    logic [DATA_W-1:0] iRD_DATA;
    logic              oBUSY;
    logic [1:0]        oTIMEOUT;

    modport slave (
        input  iREQ, iDIR, iSTB, iWDATA0, iWDATA1, iRD_DATA,
        output oGNT, oRDATA, oRVALID, oWR, oWR_DATA, oRD, oBUSY, oTIMEOUT
    );

    modport master (
        output iREQ, iDIR, iSTB, iWDATA0, iWDATA1, iRD_DATA,
        input  oGNT, oRDATA, oRVALID, oWR, oWR_DATA, oRD, oBUSY, oTIMEOUT
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Purpose:
//   Shares the single host-side FIFO port of the SDRAM controller between two
//   requesters. Whole bursts of BURST_LEN words are granted round-robin; write
//   strobes/data are routed to the controller and read data is routed back to
//   the requester that issued the reads. A drain gap of RD_LAT+1 cycles after
//   every burst guarantees that all read data of a burst has returned before
//   another requester can be granted.
//
// Ports:
//   iCLK     test clock, all logic on the rising edge
//   iRST_n   synchronous active-low reset
//   bus      sdram_port_arbiter_if.slave (requester + controller signals)
//
// Parameters:
//   DATA_W     data width (SDRAM DQ width)
//   BURST_LEN  words per grant, 2..511
//   RD_LAT     cycles from oRD to valid iRD_DATA, 1..4
//   TIMEOUT    idle cycles tolerated inside a grant (timeout build only)
//
// Build option:
//   SDRAM_ARB_TIMEOUT_EN  when defined, a grant that sees TIMEOUT consecutive
//                         cycles without an accepted word is revoked and the
//                         owner's oTIMEOUT bit is set (sticky until reset).
//                         When undefined, oTIMEOUT is tied to 0 and a stalled
//                         requester keeps the grant indefinitely.
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no grant; arbitrate among iREQ
//   S_GRANT | one requester owns the port, words are counted
//   S_DRAIN | grant dropped, waiting RD_LAT+1 cycles for read data in flight
// ----------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 128,
    parameter int RD_LAT    = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    sdram_port_arbiter_if.slave  bus
);

    localparam int DCW = $clog2(RD_LAT + 1);

    // Elaboration-time parameter range checks.
    if (BURST_LEN < 2 || BURST_LEN > 511) begin : g_bad_burst_len
        $error("sdram_port_arbiter: BURST_LEN must be in 2..511");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("sdram_port_arbiter: RD_LAT must be in 1..4");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sdram_port_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Grant bookkeeping
    logic              r_gnt_idx;     // index of the current owner
    logic              r_dir;         // direction latched at grant time
    logic [1:0]        r_gnt;
    logic [8:0]        r_cnt;         // accepted words in this burst
    logic              r_last;        // last owner, used for tie-break
    logic [DCW-1:0]    r_drain_cnt;

    // Controller side
    logic              r_wr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_rd;
    logic              r_rd_idx;      // owner of the read strobe in r_rd

    // Read return: tag pipeline aligned with the controller read latency
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_idx;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rvalid;

    // Combinational decode
    logic              w_win;
    logic              w_acc;
    logic              w_last;
    logic              w_tmo;
    logic              w_done;
    logic              w_busy;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|bus.iREQ) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / decode logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_win  = 1'b0;
        w_acc  = 1'b0;
        w_last = 1'b0;
        w_done = 1'b0;
        w_busy = (r_state != S_IDLE);

        // A lone requester wins; on a tie the one not served last wins.
        case (bus.iREQ)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase

        if (r_state == S_GRANT) begin
            w_acc = bus.iSTB[r_gnt_idx];
        end
        w_last = w_acc && (r_cnt == 9'(BURST_LEN - 1));
        w_done = w_last || w_tmo;
    end

    // ------------------------------------------------------------------------
    // Grant, strobe routing and read-return datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_gnt_idx   <= 1'b0;
            r_dir       <= 1'b0;
            r_gnt       <= 2'b00;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_drain_cnt <= '0;
            r_wr        <= 1'b0;
            r_wr_data   <= '0;
            r_rd        <= 1'b0;
            r_rd_idx    <= 1'b0;
            r_tag_vld   <= '0;
            r_tag_idx   <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 2'b00;
        end else begin
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_rvalid <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (|bus.iREQ) begin
                        r_gnt_idx <= w_win;
                        r_dir     <= bus.iDIR[w_win];
                        r_gnt     <= w_win ? 2'b10 : 2'b01;
                        r_cnt     <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_acc) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (r_dir) begin
                            r_rd     <= 1'b1;
                            r_rd_idx <= r_gnt_idx;
                        end else begin
                            r_wr      <= 1'b1;
                            r_wr_data <= r_gnt_idx ? bus.iWDATA1 : bus.iWDATA0;
                        end
                    end
                    if (w_done) begin
                        r_gnt       <= 2'b00;
                        r_last      <= r_gnt_idx;
                        r_drain_cnt <= DCW'(RD_LAT);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt != '0) begin
                        r_drain_cnt <= r_drain_cnt - DCW'(1);
                    end
                end
                default: begin
                    r_gnt <= 2'b00;
                end
            endcase

            // The tag leaves the pipeline in the cycle the controller presents
            // the matching read word, so data and owner are captured together.
            r_tag_vld[0] <= r_rd;
            r_tag_idx[0] <= r_rd_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
            if (r_tag_vld[RD_LAT-1]) begin
                r_rdata                        <= bus.iRD_DATA;
                r_rvalid[r_tag_idx[RD_LAT-1]]  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional grant timeout
    // ------------------------------------------------------------------------
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_idle_cnt;
    logic [1:0]    r_timeout;

    // Fires on the idle cycle whose increment would bring the count to TIMEOUT.
    assign w_tmo = (r_state == S_GRANT) && !w_acc &&
                   (r_idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_idle_cnt <= '0;
            r_timeout  <= 2'b00;
        end else begin
            if (r_state != S_GRANT || w_acc) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end
            if (w_tmo) begin
                r_timeout[r_gnt_idx] <= 1'b1;
            end
        end
    end

    assign bus.oTIMEOUT = r_timeout;
`else
    assign w_tmo        = 1'b0;
    assign bus.oTIMEOUT = 2'b00;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.oGNT     = r_gnt;
    assign bus.oWR      = r_wr;
    assign bus.oWR_DATA = r_wr_data;
    assign bus.oRD      = r_rd;
    assign bus.oRDATA   = r_rdata;
    assign bus.oRVALID  = r_rvalid;
    assign bus.oBUSY    = w_busy;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Purpose:
//   Self-checking bench for sdram_port_arbiter (BURST_LEN=128, RD_LAT=2,
//   TIMEOUT=16). Stimulus pushes expected write words and read returns, each
//   with the cycle it must appear, into queues; an independent monitor pops
//   and compares whenever oWR or oRVALID is seen. A small controller model
//   returns read data equal to the word address within the burst.
//   Honours SDRAM_ARB_TIMEOUT_EN for the timeout scenario.
// ----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 128;
    localparam int RD_LAT    = 2;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    // 0: controller writes, 1: read returns to req 0, 2: read returns to req 1
    exp_t exp_q [3][$];

    sdram_port_arbiter_if #(.DATA_W(DATA_W)) u_if ();

    sdram_port_arbiter #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .RD_LAT    (RD_LAT),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Controller read model: data = word address in the current burst
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_sh [RD_LAT];

    always @(posedge clk) begin
        if (u_if.oBUSY !== 1'b1) rd_addr <= '0;
        else if (u_if.oRD === 1'b1) rd_addr <= rd_addr + 1'b1;
        rd_sh[0] <= (u_if.oRD === 1'b1) ? rd_addr : 16'hDEAD;
        for (int k = 1; k < RD_LAT; k++) rd_sh[k] <= rd_sh[k-1];
    end
    assign u_if.iRD_DATA = rd_sh[RD_LAT-1];

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    string             mon_nm [3] = '{"wr_data", "rvalid0", "rvalid1"};
    logic              mon_fire;
    logic [DATA_W-1:0] mon_d;
    exp_t              mon_e;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin mon_fire = (u_if.oWR === 1'b1);        mon_d = u_if.oWR_DATA; end
                1:       begin mon_fire = (u_if.oRVALID[0] === 1'b1); mon_d = u_if.oRDATA;   end
                default: begin mon_fire = (u_if.oRVALID[1] === 1'b1); mon_d = u_if.oRDATA;   end
            endcase
            if (mon_fire) begin
                n_checks++;
                if (exp_q[k].size() == 0) begin
                    n_errors++;
                    $display("FAIL %s: unexpected output %0h at cycle %0d, none required",
                             mon_nm[k], mon_d, cyc);
                end else begin
                    mon_e = exp_q[k].pop_front();
                    if (mon_d !== mon_e.data || cyc != mon_e.cyc) begin
                        n_errors++;
                        $display("FAIL %s: got %0h at cycle %0d, required %0h at cycle %0d",
                                 mon_nm[k], mon_d, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [1:0] req, input int max, input string nm,
                            output int waited);
        waited = 0;
        while (u_if.oGNT == 2'b00 && waited < max) begin
            tick();
            waited++;
        end
        check(nm, 64'(u_if.oGNT), 64'(req));
    endtask

    // Drives n strobes for requester r (optionally every other cycle), while
    // the other requester strobes 16'hBEEF if other_stb is set. perturb drops
    // iREQ[r] and flips iDIR[r] halfway through, which must not matter.
    task automatic burst(input int r, input bit is_rd, input logic [DATA_W-1:0] base,
                         input int n, input bit gap, input bit other_stb, input bit perturb);
        int o = 1 - r;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                u_if.iSTB[r] = 1'b0;
                tick();
            end
            if (perturb && i == n / 2) begin
                u_if.iREQ[r] = 1'b0;
                u_if.iDIR[r] = ~u_if.iDIR[r];
            end
            u_if.iSTB[r] = 1'b1;
            if (r == 0) u_if.iWDATA0 = base + DATA_W'(i);
            else        u_if.iWDATA1 = base + DATA_W'(i);
            u_if.iSTB[o] = other_stb;
            if (o == 0) u_if.iWDATA0 = 16'hBEEF;
            else        u_if.iWDATA1 = 16'hBEEF;
            if (is_rd) exp_q[1+r].push_back('{data: DATA_W'(i), cyc: cyc + RD_LAT + 2});
            else       exp_q[0].push_back('{data: base + DATA_W'(i), cyc: cyc + 1});
            tick();
        end
        u_if.iSTB = 2'b00;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int w;
        int n;

        rst_n        = 1'b0;
        u_if.iREQ    = 2'b11;
        u_if.iDIR    = 2'b10;
        u_if.iSTB    = 2'b00;
        u_if.iWDATA0 = '0;
        u_if.iWDATA1 = '0;

        // Reset with both requesting: every output held at 0
        repeat (3) begin
            tick();
            check("reset_outputs",
                  {u_if.oGNT, u_if.oWR, u_if.oRD, u_if.oWR_DATA, u_if.oRDATA,
                   u_if.oRVALID, u_if.oBUSY, u_if.oTIMEOUT}, 64'd0);
        end

        // First tie goes to requester 0, one cycle after reset release
        rst_n = 1'b1;
        wait_gnt(2'b01, 20, "first_grant", w);
        check("first_grant_latency", 64'(w), 64'd1);
        check("busy_in_grant", 64'(u_if.oBUSY), 64'd1);

        // Req 0 write burst, req 1 strobing concurrently (must be ignored)
        burst(0, 1'b0, 16'h0000, BURST_LEN, 1'b0, 1'b1, 1'b0);
        check("gnt_low_after_last_write", 64'(u_if.oGNT), 64'd0);
        check("busy_in_drain", 64'(u_if.oBUSY), 64'd1);

        // Tie resolved to requester 1 after the drain gap
        u_if.iREQ[0] = 1'b0;
        wait_gnt(2'b10, 20, "second_grant_req1", w);
        check("drain_gap_after_write", 64'(w), 64'(RD_LAT + 2));

        // Req 1 read burst, req 0 strobing without a grant
        burst(1, 1'b1, 16'h0000, BURST_LEN, 1'b0, 1'b1, 1'b0);
        check("gnt_low_after_last_read", 64'(u_if.oGNT), 64'd0);

        // Req 1 alone keeps requesting: it is granted again, now as a writer
        u_if.iDIR[1] = 1'b0;
        wait_gnt(2'b10, 20, "repeat_grant_req1", w);
        check("drain_gap_after_read", 64'(w), 64'(RD_LAT + 2));

        // Gappy write, iREQ dropped and iDIR flipped mid-burst
        burst(1, 1'b0, 16'h1000, BURST_LEN, 1'b1, 1'b1, 1'b1);
        check("gnt_low_after_gappy", 64'(u_if.oGNT), 64'd0);
        repeat (10) tick();
        check("no_grant_when_idle", 64'(u_if.oGNT), 64'd0);
        check("not_busy_when_idle", 64'(u_if.oBUSY), 64'd0);

        // Reset in the middle of a read burst with words in flight
        u_if.iREQ[0] = 1'b1;
        u_if.iDIR[0] = 1'b1;
        wait_gnt(2'b01, 20, "read_grant_req0", w);
        burst(0, 1'b1, 16'h0000, 20, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        exp_q[1].delete();   // returns due after reset is sampled are aborted
        u_if.iDIR[0] = 1'b0;
        repeat (3) begin
            tick();
            check("rvalid_in_reset", 64'(u_if.oRVALID), 64'd0);
            check("gnt_busy_in_reset", 64'({u_if.oGNT, u_if.oBUSY, u_if.oRD}), 64'd0);
        end
        rst_n = 1'b1;
        wait_gnt(2'b01, 20, "grant_after_reset", w);
        check("grant_after_reset_latency", 64'(w), 64'd1);
        burst(0, 1'b0, 16'h5000, BURST_LEN, 1'b0, 1'b0, 1'b0);
        check("gnt_low_after_reset_burst", 64'(u_if.oGNT), 64'd0);

        // Stalled requester
        wait_gnt(2'b01, 20, "stall_grant_req0", w);
        burst(0, 1'b0, 16'h7000, 5, 1'b0, 1'b0, 1'b0);
        u_if.iREQ[1] = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
        n = 0;
        while (u_if.oGNT == 2'b01 && n < 200) begin
            tick();
            n++;
        end
        check("timeout_idle_cycles", 64'(n), 64'(TIMEOUT));
        check("timeout_flag", 64'(u_if.oTIMEOUT), 64'd1);
        wait_gnt(2'b10, 20, "grant_after_timeout", w);
        check("drain_gap_after_timeout", 64'(w), 64'(RD_LAT + 2));
        check("timeout_flag_sticky", 64'(u_if.oTIMEOUT), 64'd1);
`else
        n = 0;
        repeat (1000) begin
            tick();
            if (u_if.oGNT != 2'b01) n++;
        end
        check("grant_held_cycles_lost", 64'(n), 64'd0);
        check("grant_still_req0", 64'(u_if.oGNT), 64'd1);
        check("timeout_flag_off", 64'(u_if.oTIMEOUT), 64'd0);
`endif

        repeat (10) tick();
        check("scoreboard_drained",
              64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
